// File: rtl/output_coord_generator.sv
// rtl/output_coord_generator.sv - kernel top-left coordinate sequencer feeding the 3x3 depthwise address generator
module output_coord_generator #(
    parameter int ROW_COUNT   = 4,
    parameter int ADDR_WIDTH  = 6,
    parameter int KERNEL_SIZE = 3
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  i_reg_clear,
    input  logic                  i_start,
    input  logic                  i_ready,
    input  logic                  i_stride,
    input  logic [ADDR_WIDTH-1:0] i_i_size,
    output logic                  o_valid,
    output logic [ADDR_WIDTH-1:0] o_x,
    output logic [ADDR_WIDTH-1:0] o_y,
    output logic [ROW_COUNT-1:0]  o_row_id,
    output logic                  o_busy,
    output logic                  o_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] KSIZE   = ADDR_WIDTH'(KERNEL_SIZE);
    localparam logic [ROW_COUNT-1:0]  ROW_ONE = ROW_COUNT'(1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] lim_q;
    logic                  step2_q;

    logic [ADDR_WIDTH:0]   step_w;
    logic [ADDR_WIDTH:0]   lim_ext;
    logic [ADDR_WIDTH:0]   y_next;
    logic [ADDR_WIDTH:0]   x_next;
    logic [ROW_COUNT-1:0]  row_rot;

    // One extra bit keeps o_y+step from wrapping near the top of the range.
    assign step_w  = {{(ADDR_WIDTH-1){1'b0}}, step2_q, ~step2_q};
    assign lim_ext = {1'b0, lim_q};
    assign y_next  = {1'b0, o_y} + step_w;
    assign x_next  = {1'b0, o_x} + step_w;
    assign row_rot = {o_row_id[ROW_COUNT-2:0], o_row_id[ROW_COUNT-1]};

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state    <= S_IDLE;
            lim_q    <= '0;
            step2_q  <= 1'b0;
            o_valid  <= 1'b0;
            o_x      <= '0;
            o_y      <= '0;
            o_row_id <= '0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else if (i_reg_clear) begin
            state    <= S_IDLE;
            lim_q    <= '0;
            step2_q  <= 1'b0;
            o_valid  <= 1'b0;
            o_x      <= '0;
            o_y      <= '0;
            o_row_id <= '0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        o_busy <= 1'b1;
                        if (i_i_size >= KSIZE) begin
                            lim_q    <= i_i_size - KSIZE;
                            step2_q  <= i_stride;
                            o_x      <= '0;
                            o_y      <= '0;
                            o_row_id <= ROW_ONE;
                            o_valid  <= 1'b1;
                            state    <= S_RUN;
                        end else begin
                            // Tile smaller than the kernel: nothing to emit.
                            o_done <= 1'b1;
                            state  <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    if (o_valid && i_ready) begin
                        if (y_next <= lim_ext) begin
                            o_y      <= y_next[ADDR_WIDTH-1:0];
                            o_row_id <= row_rot;
                        end else if (x_next <= lim_ext) begin
                            o_y      <= '0;
                            o_x      <= x_next[ADDR_WIDTH-1:0];
                            o_row_id <= row_rot;
                        end else begin
                            o_valid  <= 1'b0;
                            o_x      <= '0;
                            o_y      <= '0;
                            o_row_id <= '0;
                            o_done   <= 1'b1;
                            state    <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state   <= S_IDLE;
                    o_valid <= 1'b0;
                    o_busy  <= 1'b0;
                    o_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
